// File: rtl/rhythm_pkg.sv
// Shared constants and types for the rhythm hit path.
// Lane count, timestamp width, output FSM states.
package rhythm_pkg;

  localparam int LANES = 4;
  localparam int TS_W  = 16;

  // Debounce window used by the push controllers upstream.
  localparam int DEBOUNCE_CYC = 20000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rhythm_rr_pick.sv
// Round-robin lane picker.
// Searches from last+1 upward, wrapping at LANES.
module rhythm_rr_pick #(
  parameter int LANES = 4,
  parameter int LW    = 2
) (
  input  logic [LANES-1:0] req_i,
  input  logic [LW-1:0]    last_i,
  output logic [LW-1:0]    grant_o,
  output logic             any_o
);

  // Scan farthest-first so the nearest requester after last wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int i = LANES; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % LANES]) begin
        grant_o = LW'((int'(last_i) + i) % LANES);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rhythm_hit_arbiter.sv
// Timestamps per-lane hit pulses and presents them
// one at a time over a valid/ready port.
module rhythm_hit_arbiter #(
  parameter int LANES = rhythm_pkg::LANES,
  parameter int TS_W  = rhythm_pkg::TS_W,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Run,
  input  logic [LANES-1:0] i_fPush,
  input  logic             i_Ready,
  output logic             o_Valid,
  output logic [LW-1:0]    o_Lane,
  output logic [TS_W-1:0]  o_Time,
  output logic [LANES-1:0] o_Overflow,
  output logic             o_Busy
);
  import rhythm_pkg::*;

  state_t           state_q, state_d;
  logic [TS_W-1:0]  cnt_q, cnt_d;
  logic [LANES-1:0] pend_q, pend_d;
  logic [LANES-1:0] ovf_q, ovf_d;
  logic [LANES-1:0] hit, clr, cap, drop;
  logic [TS_W-1:0]  ts_q [LANES];
  logic [LW-1:0]    last_q, lane_q, grant;
  logic [TS_W-1:0]  time_q;
  logic             load, any;

  rhythm_rr_pick #(
    .LANES(LANES),
    .LW   (LW)
  ) u_pick (
    .req_i  (pend_q),
    .last_i (last_q),
    .grant_o(grant),
    .any_o  (any)
  );

  // Saturating song timer, held at zero while stopped.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_Run)
      cnt_d = '0;
    else if (cnt_q != {TS_W{1'b1}})
      cnt_d = cnt_q + TS_W'(1);
  end

  // Capture, grant clear and dropped-hit detection per lane.
  always_comb begin
    load = (state_q == S_IDLE) || i_Ready;
    for (int k = 0; k < LANES; k++) begin
      hit[k]  = i_Run && i_fPush[k];
      clr[k]  = load && any && (grant == LW'(k));
      cap[k]  = hit[k] && (!pend_q[k] || clr[k]);
      drop[k] = hit[k] && pend_q[k] && !clr[k];
    end
    pend_d = (pend_q & ~clr) | hit;
    ovf_d  = i_Run ? (ovf_q | drop) : '0;
  end

  // Counter, pending bits and overflow flags.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Per-lane timestamp latches.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < LANES; k++)
        ts_q[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++)
        if (cap[k]) ts_q[k] <= cnt_q;
    end
  end

  // FSM state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: reload on idle or accepted event.
  always_comb begin
    state_d = state_q;
    if (load)
      state_d = any ? S_HOLD : S_IDLE;
  end

  // Presented event registers and round-robin pointer.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lane_q <= '0;
      time_q <= '0;
      last_q <= LW'(LANES - 1);
    end else if (load && any) begin
      lane_q <= grant;
      time_q <= ts_q[grant];
      last_q <= grant;
    end
  end

  // FSM outputs.
  always_comb begin
    o_Valid    = (state_q == S_HOLD);
    o_Lane     = lane_q;
    o_Time     = time_q;
    o_Overflow = ovf_q;
    o_Busy     = (|pend_q) || o_Valid;
  end

endmodule

// File: tb/tb_rhythm_hit_arbiter.sv
// Directed and random checks of rhythm_hit_arbiter
// against a cycle-level reference model.
module tb_rhythm_hit_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] push = 4'b0;
  logic       ready = 1'b0;
  logic       valid, busy;
  logic [1:0] lane;
  logic [15:0] tm;
  logic [3:0] ovf;

  logic       run2 = 1'b0;
  logic [3:0] push2 = 4'b0;
  logic       valid2, busy2;
  logic [1:0] lane2;
  logic [3:0] tm2;
  logic [3:0] ovf2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rhythm_hit_arbiter dut (
    .i_Clk(clk), .i_Rst(rst), .i_Run(run),
    .i_fPush(push), .i_Ready(ready),
    .o_Valid(valid), .o_Lane(lane), .o_Time(tm),
    .o_Overflow(ovf), .o_Busy(busy)
  );

  rhythm_hit_arbiter #(.LANES(4), .TS_W(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Run(run2),
    .i_fPush(push2), .i_Ready(1'b1),
    .o_Valid(valid2), .o_Lane(lane2), .o_Time(tm2),
    .o_Overflow(ovf2), .o_Busy(busy2)
  );

  // Reference model state
  int       m_cnt;
  bit       m_pend [4];
  int       m_ts [4];
  bit [3:0] m_ovf;
  int       m_last;
  bit       m_valid;
  int       m_lane, m_time;

  task automatic model_reset();
    m_cnt = 0; m_ovf = 0; m_last = 3;
    m_valid = 0; m_lane = 0; m_time = 0;
    for (int k = 0; k < 4; k++) begin
      m_pend[k] = 0; m_ts[k] = 0;
    end
  endtask

  task automatic model_step();
    int g = -1;
    bit old;
    if (!m_valid || ready) begin
      for (int i = 1; i <= 4; i++) begin
        int j = (m_last + i) % 4;
        if (g < 0 && m_pend[j]) g = j;
      end
      if (g >= 0) begin
        m_valid = 1; m_lane = g;
        m_time = m_ts[g]; m_last = g;
      end else m_valid = 0;
    end
    for (int k = 0; k < 4; k++) begin
      old = m_pend[k];
      if (g == k) m_pend[k] = 0;
      if (run && push[k]) begin
        if (old && g != k) m_ovf[k] = 1;
        else begin m_pend[k] = 1; m_ts[k] = m_cnt; end
      end
    end
    if (!run) m_ovf = 0;
    m_cnt = !run ? 0 : (m_cnt < 65535 ? m_cnt + 1 : 65535);
  endtask

  function automatic bit m_busy();
    bit b = m_valid;
    for (int k = 0; k < 4; k++) b |= m_pend[k];
    return b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    chk("m_valid", valid, m_valid);
    chk("m_busy", busy, m_busy());
    chk("m_ovf", ovf, m_ovf);
    if (m_valid) begin
      chk("m_lane", lane, m_lane);
      chk("m_time", tm, m_time);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    chk("rst_valid", valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 0;
  endtask

  task automatic run_to(int n);
    int b = 0;
    while (m_cnt != n && b < 200) begin
      tick();
      b++;
    end
    chk("run_to_budget", b < 200, 1);
  endtask

  initial begin
    #12;
    do_reset();

    // reset mid-HOLD
    run = 1; ready = 0; push = 4'b0001;
    tick();
    push = 0;
    tick();
    chk("hold_valid", valid, 1);
    chk("hold_lane", lane, 0);
    rst = 1;
    #1;
    model_reset();
    chk("async_valid", valid, 0);
    chk("async_ovf", ovf, 4'b0000);
    chk("async_busy", busy, 0);
    tick();
    rst = 0;
    chk("post_rst_idle", valid, 0);
    push = 4'b0001;
    tick();
    push = 0;
    tick();
    chk("cnt_zero_time", tm, 0);
    chk("cnt_zero_valid", valid, 1);

    // single hit
    do_reset();
    run = 1; ready = 1;
    run_to(10);
    push = 4'b0100;
    tick();
    push = 0;
    chk("single_lat", valid, 0);
    tick();
    chk("single_valid", valid, 1);
    chk("single_lane", lane, 2);
    chk("single_time", tm, 10);
    tick();
    chk("single_done", valid, 0);

    // simultaneous hits
    do_reset();
    run = 1; ready = 1;
    run_to(20);
    push = 4'b1011;
    tick();
    push = 0;
    tick();
    chk("sim_l0", lane, 0);
    chk("sim_t0", tm, 20);
    tick();
    chk("sim_l1", lane, 1);
    chk("sim_t1", tm, 20);
    tick();
    chk("sim_l3", lane, 3);
    chk("sim_t3", tm, 20);
    chk("sim_v3", valid, 1);
    tick();
    chk("sim_end_valid", valid, 0);
    chk("sim_end_busy", busy, 0);

    // backpressure and overflow
    do_reset();
    run = 1; ready = 0;
    run_to(5);
    push = 4'b0010;
    tick();
    push = 0;
    tick();
    chk("bp_lane", lane, 1);
    chk("bp_time", tm, 5);
    run_to(30);
    push = 4'b0010;
    tick();
    tick();
    push = 0;
    chk("bp_ovf", ovf, 4'b0010);
    chk("bp_stable_l", lane, 1);
    chk("bp_stable_t", tm, 5);
    tick();
    chk("bp_stable_v", valid, 1);
    chk("bp_stable_t2", tm, 5);
    ready = 1;
    tick();
    chk("bp_next_l", lane, 1);
    chk("bp_next_t", tm, 30);
    tick();
    chk("bp_drain", valid, 0);
    chk("bp_sticky", ovf, 4'b0010);
    run = 0;
    tick();
    chk("bp_ovf_clr", ovf, 4'b0000);

    // run gating
    do_reset();
    run = 1; ready = 1;
    run_to(7);
    run = 0; push = 4'b1111;
    repeat (3) tick();
    chk("gate_valid", valid, 0);
    chk("gate_ovf", ovf, 4'b0000);
    chk("gate_busy", busy, 0);
    push = 4'b0001; run = 1;
    tick();
    push = 0;
    tick();
    chk("gate_lane", lane, 0);
    chk("gate_time", tm, 0);

    // saturation on the 4-bit instance
    run2 = 1;
    repeat (20) tick();
    push2 = 4'b1000;
    tick();
    push2 = 0;
    tick();
    chk("sat_valid", valid2, 1);
    chk("sat_lane", lane2, 3);
    chk("sat_time", tm2, 15);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      run = ($urandom_range(0, 15) != 0);
      ready = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 4; k++)
        push[k] = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rhythm_hit_arbiter.md
RHYTHM_HIT_ARBITER -- requirements
Module: rhythm_hit_arbiter

Interface
REQ-001 Parameter LANES, default 4: number of button lanes; each lane is fed by one debounced one-cycle push pulse.
REQ-002 Parameter TS_W, default 16: width of the hit timestamp in clock cycles.
REQ-003 Port i_Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port i_Rst  input  1  reset, asynchronous and active-high.
REQ-005 Port i_Run  input  1  song-running enable; gates the timestamp counter and hit capture.
REQ-006 Port i_fPush  input  LANES  per-lane one-cycle hit pulses.
REQ-007 Port i_Ready  input  1  judge-side ready for the hit event.
REQ-008 Port o_Valid  output  1  hit event valid.
REQ-009 Port o_Lane  output  clog2(LANES)  lane index of the presented event.
REQ-010 Port o_Time  output  TS_W  timestamp of the presented event.
REQ-011 Port o_Overflow  output  LANES  sticky per-lane dropped-hit flags.
REQ-012 Port o_Busy  output  1  high when any lane is pending or o_Valid=1.

Function
REQ-013 Timestamp counter: while i_Run=1, +1 per cycle; it saturates at 2^TS_W-1 and never wraps; while i_Run=0 it is held at 0.
REQ-014 Capture: with i_Run=1 and i_fPush[k]=1, pending[k] sets and time[k] latches the current counter value at that edge.
REQ-015 Capture conflict: if pending[k]=1 and lane k is not granted in the same cycle, the pulse is dropped, time[k] is unchanged, and o_Overflow[k] sets.
REQ-016 Same-cycle grant and pulse on lane k: the grant takes the old entry and the new pulse is captured; no overflow is flagged.
REQ-017 With i_Run=0, pulses are ignored and do not flag overflow; existing pending entries still drain.
REQ-018 o_Overflow clears while i_Run=0 and is sticky while i_Run=1.
REQ-019 Output FSM has two states:
- S_IDLE: o_Valid=0.
- S_HOLD: o_Valid=1.
REQ-020 Load condition: the FSM loads when in S_IDLE, or in S_HOLD with i_Ready=1.
- Any lane pending: select one lane, register o_Lane/o_Time, clear its pending bit, and go to (or stay in) S_HOLD.
- No lane pending: go to S_IDLE.
REQ-021 In S_HOLD with i_Ready=0, o_Valid, o_Lane and o_Time stay stable.
REQ-022 Selection is round-robin: search starts at lane r_Last+1 modulo LANES, and r_Last updates to the granted lane.
REQ-023 Latency from idle: pulse sampled at edge t, pending at edge t, o_Valid=1 after edge t+1.
REQ-024 With i_Ready held at 1, throughput is one event per cycle.
REQ-025 o_Busy is the combinational OR of the pending bits and o_Valid.

Reset
REQ-026 On i_Rst=1, asynchronously, all of the following are cleared:
- timestamp counter = 0, pending bits = 0, time[] = 0;
- o_Valid = 0, o_Lane = 0, o_Time = 0, o_Overflow = 0;
- state = S_IDLE, r_Last = LANES-1, so lane 0 has first priority.
REQ-027 Reset asserted mid-transfer discards pending and presented events; no event is emitted after release until a new pulse arrives.

Structure
REQ-028 Shared package rhythm_pkg holds LANES, TS_W, the state encodings S_IDLE/S_HOLD, and the debounce constant used by the push controllers.
REQ-029 The round-robin search is a separate combinational sub-module, rhythm_rr_pick.
- Inputs: request vector, last-grant index.
- Outputs: grant index, any-request.
REQ-030 The top level contains only the counter, the capture registers, and the output FSM.

Verification
REQ-031 Reset: assert i_Rst mid-HOLD -> o_Valid=0, o_Overflow=4'b0000, and the counter reads 0 at once, without waiting for a clock edge.
REQ-032 Single hit: i_Run=1, i_Ready=1, i_fPush=4'b0100 while counter=10 -> one cycle of o_Valid=1 with o_Lane=2, o_Time=10, after edge t+1.
REQ-033 Simultaneous hits: i_fPush=4'b1011 at counter=20, i_Ready=1, fresh reset -> events in order lane 0, 1, 3 on consecutive cycles, all with o_Time=20; o_Busy falls afterwards.
REQ-034 Backpressure and overflow: i_Ready=0 and lane 1 presented, then lane 1 pulsed at counter 30 (pending) and again at 31 -> o_Overflow=4'b0010. Raising i_Ready then yields lane-1 events with o_Time 30 only; o_Lane/o_Time stay stable while i_Ready=0.
REQ-035 Run gating: i_Run=0 with pulses on all lanes -> no o_Valid, counter stays 0, o_Overflow stays 0. Raising i_Run restarts the count from 0.
REQ-036 Saturation: TS_W=4, i_Run=1 for 20 cycles, then pulse lane 3 -> o_Time=15.
